// File: rtl/vdot_unit.sv
// ---------------------------------------------------------------------------
// vdot_unit
// Pipelined signed dot-product engine. Each accepted beat carries two 64-bit
// words of four signed 16-bit lanes; the lane-wise products are summed into a
// 64-bit signed accumulator over 'len' beats, and the final sum (optionally
// clamped at zero by ReLU) is returned through a valid/ready result port.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset, aborts any operation
//   start      one-cycle request, honoured only while idle
//   len        number of word pairs for the operation (0 = empty result)
//   relu       clamp a negative result to zero
//   in_valid   op_a/op_b carry a beat
//   in_ready   engine takes a beat this cycle (only while accumulating)
//   op_a/op_b  operand words, lane i = bits [16i+15:16i]
//   res_valid  res_data valid, held until res_ready
//   res_ready  consumer takes the result
//   res_data   signed 64-bit result
//   busy       engine is not idle
// ---------------------------------------------------------------------------
module vdot_unit #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             relu,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      op_a,
    input  logic [63:0]      op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [LEN_W-1:0]   cnt;
    logic               relu_l;
    logic signed [63:0] acc;
    logic               p_v;
    logic signed [31:0] prod [4];
    logic [63:0]        lane_sum;
    logic               beat_acc;
    logic               start_acc;
    logic               drain_done;

    assign beat_acc   = in_valid && in_ready;
    assign start_acc  = (state == IDLE) && start;
    assign drain_done = (state == DRAIN) && !p_v;

    // State register. Reset returns to IDLE regardless of what else happens
    // in the same cycle, which is what discards an in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. DRAIN waits for the product stage
    // to empty so the last beat has been folded into the accumulator before
    // the result is captured.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (cnt == LEN_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!p_v) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Stage 1: four signed 16x16 multipliers. Products are only captured on
    // an accepted beat; p_v marks that stage 2 has fresh products to add.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_v <= 1'b0;
            cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                prod[i] <= '0;
            end
        end else begin
            p_v <= beat_acc;
            if (start_acc) begin
                cnt <= len;
            end else if (beat_acc) begin
                cnt <= cnt - LEN_W'(1);
            end
            if (beat_acc) begin
                for (int i = 0; i < 4; i++) begin
                    prod[i] <= $signed(op_a[16*i +: 16]) * $signed(op_b[16*i +: 16]);
                end
            end
        end
    end

    // Sign-extended sum of the four registered products.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < 4; i++) begin
            lane_sum = lane_sum + {{32{prod[i][31]}}, prod[i]};
        end
    end

    // Stage 2 accumulator and result register. Starting an operation clears
    // both, so a zero-length operation reports zero. The result is captured
    // once, on the edge DRAIN hands over to DONE, and then held stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            relu_l   <= 1'b0;
            res_data <= '0;
        end else begin
            if (start_acc) begin
                acc      <= '0;
                relu_l   <= relu;
                res_data <= '0;
            end else if (p_v) begin
                acc <= acc + $signed(lane_sum);
            end
            if (drain_done) begin
                res_data <= (relu_l && acc[63]) ? 64'd0 : acc;
            end
        end
    end

endmodule

// File: tb/tb_vdot_unit.sv
// ---------------------------------------------------------------------------
// tb_vdot_unit
// Directed, self-checking bench for vdot_unit. A small reference model sums
// the lane products of every driven beat; the expected result of each
// operation is pushed to a scoreboard queue and popped when the engine
// presents its result.
// ---------------------------------------------------------------------------
module tb_vdot_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        relu;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic        busy;

    int vectors;
    int miscompares;

    logic [63:0]        sb [$];
    logic signed [63:0] model_acc;
    logic               model_relu;

    vdot_unit #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .relu      (relu),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge, where all
    // checks and new input drives happen.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    function automatic logic signed [63:0] dotWord(input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] s;
        logic signed [63:0] xa;
        logic signed [63:0] xb;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            xa = $signed(a[16*i +: 16]);
            xb = $signed(b[16*i +: 16]);
            s  = s + xa * xb;
        end
        return s;
    endfunction

    // Request an operation; the start edge is consumed here.
    task automatic startOp(input logic [7:0] l, input logic r);
        start      = 1'b1;
        len        = l;
        relu       = r;
        model_acc  = '0;
        model_relu = r;
        step();
        start = 1'b0;
        len   = 8'($urandom);
        relu  = 1'($urandom);
    endtask

    // Idle for 'gap' cycles with junk on the operand bus, then deliver one
    // beat. The beat is accepted on the edge consumed at the end.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input int gap);
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            op_a = {$urandom, $urandom};
            op_b = {$urandom, $urandom};
            step();
        end
        in_valid  = 1'b1;
        op_a      = a;
        op_b      = b;
        model_acc = model_acc + dotWord(a, b);
        step();
        in_valid = 1'b0;
        op_a     = {$urandom, $urandom};
        op_b     = {$urandom, $urandom};
    endtask

    task automatic pushExpected();
        sb.push_back((model_relu && model_acc < 0) ? 64'd0 : model_acc);
    endtask

    task automatic popCompare(input string tag);
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%h expected=<empty scoreboard>", tag, res_data);
        end else begin
            checkOutput(tag, res_data, sb.pop_front());
        end
    endtask

    // Wait a bounded number of cycles for a result, score it, and let the
    // transfer edge pass (res_ready is expected high).
    task automatic collectResult(input string tag, input int budget);
        int n;
        n = 0;
        while (!res_valid && n < budget) begin
            step();
            n++;
        end
        checkOutput({tag, "_valid"}, 64'(res_valid), 64'd1);
        if (res_valid) begin
            popCompare(tag);
        end
        step();
        checkOutput({tag, "_valid_drop"}, 64'(res_valid), 64'd0);
        checkOutput({tag, "_busy_drop"}, 64'(busy), 64'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b1;
        len         = 8'd5;
        relu        = 1'b0;
        in_valid    = 1'b1;
        op_a        = {$urandom, $urandom};
        op_b        = {$urandom, $urandom};
        res_ready   = 1'b1;
        model_acc   = '0;
        model_relu  = 1'b0;

        // Reset with start and random inputs active for two cycles.
        for (int c = 0; c < 2; c++) begin
            step();
            checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
            checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
            checkOutput("rst_busy", 64'(busy), 64'd0);
            checkOutput("rst_res_data", res_data, 64'd0);
            op_a = {$urandom, $urandom};
            op_b = {$urandom, $urandom};
        end
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        step();
        checkOutput("post_rst_busy", 64'(busy), 64'd0);

        // Single beat, exact latency.
        startOp(8'd1, 1'b0);
        checkOutput("single_in_ready", 64'(in_ready), 64'd1);
        checkOutput("single_busy", 64'(busy), 64'd1);
        applyStimulus(64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 0);
        pushExpected();
        checkOutput("single_in_ready_drop", 64'(in_ready), 64'd0);
        step();
        checkOutput("single_valid_T1", 64'(res_valid), 64'd0);
        step();
        checkOutput("single_valid_T2", 64'(res_valid), 64'd1);
        popCompare("single_data");
        checkOutput("single_const", res_data, 64'h0000_0000_0000_0046);
        step();
        checkOutput("single_busy_drop", 64'(busy), 64'd0);
        checkOutput("single_valid_drop", 64'(res_valid), 64'd0);

        // Extreme lane values with gaps of 0/2/1 between beats.
        startOp(8'd3, 1'b0);
        applyStimulus(64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 0);
        applyStimulus(64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 2);
        checkOutput("extreme_mid_in_ready", 64'(in_ready), 64'd1);
        applyStimulus(64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 1);
        checkOutput("extreme_in_ready_drop", 64'(in_ready), 64'd0);
        checkOutput("extreme_model", 64'(model_acc), 64'h0000_0003_0000_0000);
        pushExpected();
        collectResult("extreme", 6);

        // Negative result without and with ReLU.
        startOp(8'd1, 1'b0);
        applyStimulus(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0005, 0);
        pushExpected();
        collectResult("sign_norelu", 6);
        startOp(8'd1, 1'b1);
        applyStimulus(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0005, 0);
        pushExpected();
        collectResult("sign_relu", 6);

        // Zero-length operation, stalled result, start pulse while DONE.
        res_ready = 1'b0;
        startOp(8'd0, 1'b0);
        pushExpected();
        checkOutput("len0_valid", 64'(res_valid), 64'd1);
        popCompare("len0_data");
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                start = 1'b1;
                len   = 8'd7;
            end
            step();
            start = 1'b0;
            checkOutput("hold_valid", 64'(res_valid), 64'd1);
            checkOutput("hold_data", res_data, 64'd0);
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
        end
        res_ready = 1'b1;
        step();
        checkOutput("len0_valid_drop", 64'(res_valid), 64'd0);
        checkOutput("len0_busy_drop", 64'(busy), 64'd0);

        // Abort after two beats, then a clean operation.
        startOp(8'd4, 1'b0);
        applyStimulus(64'h0001_0001_0001_0001, 64'h0100_0100_0100_0100, 0);
        applyStimulus(64'h0001_0001_0001_0001, 64'h0100_0100_0100_0100, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_valid", 64'(res_valid), 64'd0);
        checkOutput("abort_data", res_data, 64'd0);
        startOp(8'd1, 1'b0);
        applyStimulus(64'h0000_0000_0000_0003, 64'h0000_0000_0000_0003, 0);
        pushExpected();
        collectResult("after_abort", 6);

        checkOutput("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
